// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand selection and hazard detection.
// Define ID_EX_FORWARDING_EN for EX/MEM + MEM/WB forwarding with load-use stalls; default build stalls on every RAW.
module id_ex_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic            id_alu_src,
   input  logic            id_uses_rs2,
   input  logic [3:0]      id_alu_op,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic            flush,
   input  logic [4:0]      exm_rd,
   input  logic            exm_reg_write,
   input  logic [XLEN-1:0] exm_result,
   input  logic [4:0]      mwb_rd,
   input  logic            mwb_reg_write,
   input  logic [XLEN-1:0] mwb_result,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      alu_op,
   output logic            ex_valid,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic [4:0]      ex_rd,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_store_data,
   output logic            hazard_stall
);
   localparam logic [3:0] ALU_ADD = 4'h0;

   logic            ex_valid_q, ex_valid_d;
   logic            ex_reg_write_q, ex_reg_write_d;
   logic            ex_mem_read_q, ex_mem_read_d;
   logic            ex_mem_write_q, ex_mem_write_d;
   logic [4:0]      ex_rd_q, ex_rd_d;
   logic [3:0]      alu_op_q, alu_op_d;
   logic [XLEN-1:0] ex_pc_q, ex_pc_d;
   logic [4:0]      rs1_q, rs1_d;
   logic [4:0]      rs2_q, rs2_d;
   logic [XLEN-1:0] rs1_data_q, rs1_data_d;
   logic [XLEN-1:0] rs2_data_q, rs2_data_d;
   logic [XLEN-1:0] imm_q, imm_d;
   logic            alu_src_q, alu_src_d;
   logic            bubble;
   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;

   // Datapath fields are always captured; only the control fields are squashed for a bubble.
   always_comb begin
      bubble         = flush || hazard_stall || !id_valid;
      ex_pc_d        = id_pc;
      rs1_d          = id_rs1;
      rs2_d          = id_rs2;
      rs1_data_d     = id_rs1_data;
      rs2_data_d     = id_rs2_data;
      imm_d          = id_imm;
      alu_src_d      = id_alu_src;
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
      ex_mem_write_d = 1'b0;
      ex_rd_d        = 5'd0;
      alu_op_d       = ALU_ADD;
      if (!bubble) begin
         ex_valid_d     = 1'b1;
         ex_reg_write_d = id_reg_write;
         ex_mem_read_d  = id_mem_read;
         ex_mem_write_d = id_mem_write;
         ex_rd_d        = id_rd;
         alu_op_d       = id_alu_op;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_q     <= 1'b0;
         ex_reg_write_q <= 1'b0;
         ex_mem_read_q  <= 1'b0;
         ex_mem_write_q <= 1'b0;
         ex_rd_q        <= 5'd0;
         alu_op_q       <= ALU_ADD;
         ex_pc_q        <= '0;
         rs1_q          <= 5'd0;
         rs2_q          <= 5'd0;
         rs1_data_q     <= '0;
         rs2_data_q     <= '0;
         imm_q          <= '0;
         alu_src_q      <= 1'b0;
      end else begin
         ex_valid_q     <= ex_valid_d;
         ex_reg_write_q <= ex_reg_write_d;
         ex_mem_read_q  <= ex_mem_read_d;
         ex_mem_write_q <= ex_mem_write_d;
         ex_rd_q        <= ex_rd_d;
         alu_op_q       <= alu_op_d;
         ex_pc_q        <= ex_pc_d;
         rs1_q          <= rs1_d;
         rs2_q          <= rs2_d;
         rs1_data_q     <= rs1_data_d;
         rs2_data_q     <= rs2_data_d;
         imm_q          <= imm_d;
         alu_src_q      <= alu_src_d;
      end
   end

`ifdef ID_EX_FORWARDING_EN
   // EX/MEM is the younger result, so it wins over MEM/WB; x0 is never forwarded.
   always_comb begin
      rs1_fwd = rs1_data_q;
      if (exm_reg_write && exm_rd != 5'd0 && exm_rd == rs1_q)
         rs1_fwd = exm_result;
      else if (mwb_reg_write && mwb_rd != 5'd0 && mwb_rd == rs1_q)
         rs1_fwd = mwb_result;
   end

   always_comb begin
      rs2_fwd = rs2_data_q;
      if (exm_reg_write && exm_rd != 5'd0 && exm_rd == rs2_q)
         rs2_fwd = exm_result;
      else if (mwb_reg_write && mwb_rd != 5'd0 && mwb_rd == rs2_q)
         rs2_fwd = mwb_result;
   end

   // Only a load in EX cannot be forwarded in time; one bubble resolves it.
   assign hazard_stall = !flush && id_valid && ex_valid_q && ex_mem_read_q &&
                         (ex_rd_q != 5'd0) &&
                         ((id_rs1 == ex_rd_q) || (id_uses_rs2 && (id_rs2 == ex_rd_q)));
`else
   logic rs1_hit;
   logic rs2_hit;
   logic unused_fwd_inputs;

   assign rs1_fwd = rs1_data_q;
   assign rs2_fwd = rs2_data_q;

   // Wait until no in-flight writer (EX, EX/MEM, MEM/WB) targets a source register.
   assign rs1_hit = (id_rs1 != 5'd0) &&
                    ((ex_valid_q && ex_reg_write_q && (id_rs1 == ex_rd_q)) ||
                     (exm_reg_write && (id_rs1 == exm_rd)) ||
                     (mwb_reg_write && (id_rs1 == mwb_rd)));
   assign rs2_hit = id_uses_rs2 && (id_rs2 != 5'd0) &&
                    ((ex_valid_q && ex_reg_write_q && (id_rs2 == ex_rd_q)) ||
                     (exm_reg_write && (id_rs2 == exm_rd)) ||
                     (mwb_reg_write && (id_rs2 == mwb_rd)));
   assign hazard_stall = !flush && id_valid && (rs1_hit || rs2_hit);

   assign unused_fwd_inputs = ^{exm_result, mwb_result, rs1_q, rs2_q, ex_mem_read_q};
`endif

   assign alu_a         = rs1_fwd;
   assign alu_b         = alu_src_q ? imm_q : rs2_fwd;
   assign ex_store_data = rs2_fwd;
   assign alu_op        = alu_op_q;
   assign ex_valid      = ex_valid_q;
   assign ex_reg_write  = ex_reg_write_q;
   assign ex_mem_read   = ex_mem_read_q;
   assign ex_mem_write  = ex_mem_write_q;
   assign ex_rd         = ex_rd_q;
   assign ex_pc         = ex_pc_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against an instruction-level model.
// Works with and without ID_EX_FORWARDING_EN; expectations follow the macro.
module tb_id_ex_stage;
   localparam logic [3:0] ALU_ADD = 4'h0;
`ifdef ID_EX_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk, rst;
   logic        id_valid, id_alu_src, id_uses_rs2, id_reg_write, id_mem_read, id_mem_write, flush;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [3:0]  id_alu_op;
   logic [4:0]  exm_rd, mwb_rd;
   logic        exm_reg_write, mwb_reg_write;
   logic [31:0] exm_result, mwb_result;
   logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
   logic [3:0]  alu_op;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall;
   logic [4:0]  ex_rd;

   int n_pass = 0;
   int n_total = 0;

   // The instruction the model believes currently sits in EX.
   typedef struct packed {
      logic        v, rw, mr, mw, src;
      logic [4:0]  rd, rs1, rs2;
      logic [3:0]  op;
      logic [31:0] pc, d1, d2, imm;
   } ex_t;
   ex_t m;

   id_ex_stage #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_alu_src(id_alu_src), .id_uses_rs2(id_uses_rs2), .id_alu_op(id_alu_op),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .flush(flush), .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
      .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_valid(ex_valid),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_store_data(ex_store_data), .hazard_stall(hazard_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] d);
      if (FWD && rs != 0 && exm_reg_write && exm_rd == rs) return exm_result;
      if (FWD && rs != 0 && mwb_reg_write && mwb_rd == rs) return mwb_result;
      return d;
   endfunction

   function automatic logic ref_stall();
      logic [4:0] writers[$];
      if (flush || !id_valid) return 1'b0;
      if (FWD)
         return m.v && m.mr && m.rd != 0 &&
                (id_rs1 == m.rd || (id_uses_rs2 && id_rs2 == m.rd));
      if (m.v && m.rw) writers.push_back(m.rd);
      if (exm_reg_write) writers.push_back(exm_rd);
      if (mwb_reg_write) writers.push_back(mwb_rd);
      foreach (writers[i]) begin
         if (id_rs1 != 0 && id_rs1 == writers[i]) return 1'b1;
         if (id_uses_rs2 && id_rs2 != 0 && id_rs2 == writers[i]) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_reset();
      m = '0;
      m.op = ALU_ADD;
   endtask

   task automatic set_idle();
      id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_src = 0; id_uses_rs2 = 0;
      id_alu_op = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; flush = 0;
      exm_rd = 0; exm_reg_write = 0; exm_result = 0;
      mwb_rd = 0; mwb_reg_write = 0; mwb_result = 0;
   endtask

   task automatic drive_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] imm, input logic src, input logic uses2,
                           input logic [3:0] op, input logic rw, input logic mr, input logic mw);
      id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_src = src;
      id_uses_rs2 = uses2; id_alu_op = op; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
   endtask

   // One clock edge; the model advances with the inputs present at the edge.
   task automatic tick();
      logic st;
      st = ref_stall();
      @(posedge clk);
      if (!rst) begin
         m.pc = id_pc; m.rs1 = id_rs1; m.rs2 = id_rs2; m.d1 = id_rs1_data;
         m.d2 = id_rs2_data; m.imm = id_imm; m.src = id_alu_src;
         if (flush || st || !id_valid) begin
            m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.rd = 0; m.op = ALU_ADD;
         end else begin
            m.v = 1; m.rw = id_reg_write; m.mr = id_mem_read; m.mw = id_mem_write;
            m.rd = id_rd; m.op = id_alu_op;
         end
      end
      #1;
   endtask

   task automatic drain();
      set_idle();
      repeat (2) tick();
   endtask

   task automatic test_reset();
      set_idle();
      rst = 1;
      drive_id(32'h1234, 5'd1, 5'd2, 5'd9, 32'h11, 32'h22, 32'h33, 1'b1, 1'b1, 4'h7, 1'b1, 1'b1, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_total++; if (ex_valid !== 1'b0) $display("FAIL rst_valid: got %0h expected 0", ex_valid); else n_pass++;
      n_total++; if (ex_rd !== 5'd0) $display("FAIL rst_rd: got %0h expected 0", ex_rd); else n_pass++;
      n_total++; if (ex_pc !== 32'h0) $display("FAIL rst_pc: got %0h expected 0", ex_pc); else n_pass++;
      n_total++; if (alu_op !== ALU_ADD) $display("FAIL rst_op: got %0h expected %0h", alu_op, ALU_ADD); else n_pass++;
      n_total++; if (alu_b !== 32'h0) $display("FAIL rst_alu_b: got %0h expected 0", alu_b); else n_pass++;
      n_total++; if (ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0)
         $display("FAIL rst_ctrl: got %0b%0b expected 00", ex_reg_write, ex_mem_read); else n_pass++;
      rst = 0;
      tick();
      n_total++; if (ex_valid !== 1'b1 || ex_pc !== 32'h1234 || alu_op !== 4'h7)
         $display("FAIL rst_first_capture: got v=%0h pc=%0h op=%0h expected v=1 pc=1234 op=7", ex_valid, ex_pc, alu_op);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      drain();
      drive_id(32'h100, 5'd2, 5'd0, 5'd3, 32'h1000, 32'h0, 32'h4, 1'b1, 1'b0, 4'h9, 1'b1, 1'b1, 1'b0);
      tick();
      drive_id(32'h104, 5'd3, 5'd1, 5'd4, 32'h0, 32'h5, 32'h0, 1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
      #1;
      n_total++; if (ex_valid !== 1'b1 || alu_op !== 4'h9)
         $display("FAIL arst_pre: got v=%0h op=%0h expected v=1 op=9", ex_valid, alu_op); else n_pass++;
      n_total++; if (hazard_stall !== 1'b1) $display("FAIL arst_stall_pre: got %0h expected 1", hazard_stall); else n_pass++;
      rst = 1;
      #1;
      model_reset();
      n_total++; if (ex_valid !== 1'b0 || alu_op !== ALU_ADD)
         $display("FAIL arst_async: got v=%0h op=%0h expected v=0 op=%0h", ex_valid, alu_op, ALU_ADD); else n_pass++;
      n_total++; if (hazard_stall !== 1'b0) $display("FAIL arst_stall_clear: got %0h expected 0", hazard_stall); else n_pass++;
      rst = 0;
      #1;
      tick();
      n_total++; if (ex_valid !== 1'b1 || ex_rd !== 5'd4 || ex_pc !== 32'h104)
         $display("FAIL arst_release: got v=%0h rd=%0d pc=%0h expected v=1 rd=4 pc=104", ex_valid, ex_rd, ex_pc);
      else n_pass++;
   endtask

   task automatic test_fwd_exm();
      drain();
      drive_id(32'h200, 5'd5, 5'd0, 5'd6, 32'h3, 32'h0, 32'h0, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0);
      tick();
      set_idle();
      exm_rd = 5'd5; exm_reg_write = 1; exm_result = 32'h10;
      #1;
      n_total++; if (alu_a !== (FWD ? 32'h10 : 32'h3))
         $display("FAIL fwd_exm: got %0h expected %0h", alu_a, FWD ? 32'h10 : 32'h3); else n_pass++;
      exm_reg_write = 0; mwb_rd = 5'd5; mwb_reg_write = 1; mwb_result = 32'h20;
      #1;
      n_total++; if (alu_a !== (FWD ? 32'h20 : 32'h3))
         $display("FAIL fwd_mwb: got %0h expected %0h", alu_a, FWD ? 32'h20 : 32'h3); else n_pass++;
   endtask

   task automatic test_double_match();
      drain();
      drive_id(32'h240, 5'd0, 5'd7, 5'd8, 32'h0, 32'h22, 32'h99, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0);
      tick();
      set_idle();
      exm_rd = 5'd7; exm_reg_write = 1; exm_result = 32'hA;
      mwb_rd = 5'd7; mwb_reg_write = 1; mwb_result = 32'hB;
      #1;
      n_total++; if (alu_b !== (FWD ? 32'hA : 32'h22))
         $display("FAIL dbl_alu_b: got %0h expected %0h", alu_b, FWD ? 32'hA : 32'h22); else n_pass++;
      n_total++; if (ex_store_data !== (FWD ? 32'hA : 32'h22))
         $display("FAIL dbl_store: got %0h expected %0h", ex_store_data, FWD ? 32'hA : 32'h22); else n_pass++;
      exm_rd = 5'd6;
      #1;
      n_total++; if (alu_b !== (FWD ? 32'hB : 32'h22))
         $display("FAIL dbl_mwb_only: got %0h expected %0h", alu_b, FWD ? 32'hB : 32'h22); else n_pass++;
      exm_rd = 5'd0; mwb_rd = 5'd0;
      drive_id(32'h244, 5'd0, 5'd0, 5'd0, 32'h0, 32'h55, 32'h0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
      tick();
      n_total++; if (alu_b !== 32'h55) $display("FAIL x0_no_fwd: got %0h expected 55", alu_b); else n_pass++;
      drive_id(32'h248, 5'd0, 5'd0, 5'd0, 32'h0, 32'h66, 32'h77, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
      tick();
      n_total++; if (alu_b !== 32'h77 || ex_store_data !== 32'h66)
         $display("FAIL imm_select: got b=%0h st=%0h expected b=77 st=66", alu_b, ex_store_data); else n_pass++;
   endtask

   task automatic test_load_use();
      drain();
      drive_id(32'h300, 5'd2, 5'd0, 5'd3, 32'h1000, 32'h0, 32'h4, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
      tick();
      drive_id(32'h304, 5'd3, 5'd1, 5'd4, 32'h0, 32'h5, 32'h0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
      #1;
      n_total++; if (hazard_stall !== 1'b1) $display("FAIL lu_stall: got %0h expected 1", hazard_stall); else n_pass++;
      tick();
      n_total++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0)
         $display("FAIL lu_bubble: got v=%0h rd=%0d expected v=0 rd=0", ex_valid, ex_rd); else n_pass++;
      exm_rd = 5'd3; exm_reg_write = 1; exm_result = 32'h77;
      #1;
      n_total++; if (hazard_stall !== (FWD ? 1'b0 : 1'b1))
         $display("FAIL lu_one_bubble: got %0h expected %0h", hazard_stall, FWD ? 1'b0 : 1'b1); else n_pass++;
      tick();
      n_total++; if (ex_valid !== FWD || alu_a !== ref_operand(m.rs1, m.d1))
         $display("FAIL lu_enter: got v=%0h a=%0h expected v=%0h a=%0h", ex_valid, alu_a, FWD, ref_operand(m.rs1, m.d1));
      else n_pass++;
      n_total++; if (alu_a !== (FWD ? 32'h77 : 32'h0))
         $display("FAIL lu_alu_a: got %0h expected %0h", alu_a, FWD ? 32'h77 : 32'h0); else n_pass++;
   endtask

   task automatic test_flush_stall();
      drain();
      drive_id(32'h340, 5'd2, 5'd0, 5'd3, 32'h1000, 32'h0, 32'h4, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
      tick();
      drive_id(32'h344, 5'd3, 5'd1, 5'd4, 32'h0, 32'h5, 32'h0, 1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
      flush = 1;
      #1;
      n_total++; if (hazard_stall !== 1'b0) $display("FAIL flush_stall: got %0h expected 0", hazard_stall); else n_pass++;
      tick();
      n_total++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_rd !== 5'd0 || alu_op !== ALU_ADD)
         $display("FAIL flush_bubble: got v=%0h rw=%0h rd=%0d op=%0h expected 0 0 0 %0h",
                  ex_valid, ex_reg_write, ex_rd, alu_op, ALU_ADD);
      else n_pass++;
      flush = 0;
   endtask

   // addi x2,x0,1 followed by add x3,x2,x2 with a simple downstream pipeline driving EX/MEM and MEM/WB.
   task automatic test_raw_stall();
      int stage = 0;
      int stalls = 0;
      bit got = 0;
      drain();
      drive_id(32'h400, 5'd0, 5'd0, 5'd2, 32'h0, 32'h0, 32'h1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      tick();
      for (int c = 0; c < 8 && !got; c++) begin
         exm_reg_write = (stage == 1); exm_rd = (stage == 1) ? 5'd2 : 5'd0; exm_result = 32'h1;
         mwb_reg_write = (stage == 2); mwb_rd = (stage == 2) ? 5'd2 : 5'd0; mwb_result = 32'h1;
         drive_id(32'h404, 5'd2, 5'd2, 5'd3, (stage >= 3) ? 32'h1 : 32'h0, (stage >= 3) ? 32'h1 : 32'h0,
                  32'h0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
         #1;
         if (hazard_stall === 1'b1) stalls++;
         tick();
         stage++;
         if (m.v && m.rd == 5'd3) got = 1;
      end
      exm_reg_write = (stage == 1); exm_rd = (stage == 1) ? 5'd2 : 5'd0;
      mwb_reg_write = (stage == 2); mwb_rd = (stage == 2) ? 5'd2 : 5'd0;
      id_valid = 0;
      #1;
      n_total++; if (got !== 1'b1) $display("FAIL raw_capture: got %0b expected 1 within 8 cycles", got); else n_pass++;
      n_total++; if (stalls != (FWD ? 0 : 3)) $display("FAIL raw_stall_cycles: got %0d expected %0d", stalls, FWD ? 0 : 3); else n_pass++;
      n_total++; if (alu_a !== 32'h1 || alu_b !== 32'h1)
         $display("FAIL raw_operands: got a=%0h b=%0h expected a=1 b=1", alu_a, alu_b); else n_pass++;
   endtask

   task automatic test_random();
      logic [12:0] got_ctrl, exp_ctrl;
      logic [31:0] exp_b;
      drain();
      for (int i = 0; i < 400; i++) begin
         id_valid = ($urandom_range(3) != 0);
         id_pc = $urandom; id_rs1 = 5'($urandom_range(7)); id_rs2 = 5'($urandom_range(7));
         id_rd = 5'($urandom_range(7)); id_rs1_data = $urandom; id_rs2_data = $urandom;
         id_imm = $urandom; id_alu_src = 1'($urandom_range(1)); id_uses_rs2 = 1'($urandom_range(1));
         id_alu_op = 4'($urandom_range(15)); id_reg_write = 1'($urandom_range(1));
         id_mem_read = ($urandom_range(2) == 0); id_mem_write = 1'($urandom_range(1));
         flush = ($urandom_range(9) == 0);
         exm_rd = 5'($urandom_range(7)); exm_reg_write = 1'($urandom_range(1)); exm_result = $urandom;
         mwb_rd = 5'($urandom_range(7)); mwb_reg_write = 1'($urandom_range(1)); mwb_result = $urandom;
         #2;
         got_ctrl = {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd, alu_op};
         exp_ctrl = {m.v, m.rw, m.mr, m.mw, m.rd, m.op};
         exp_b = m.src ? m.imm : ref_operand(m.rs2, m.d2);
         n_total++; if (hazard_stall !== ref_stall())
            $display("FAIL rnd_stall[%0d]: got %0h expected %0h", i, hazard_stall, ref_stall()); else n_pass++;
         n_total++; if (got_ctrl !== exp_ctrl)
            $display("FAIL rnd_ctrl[%0d]: got %0h expected %0h", i, got_ctrl, exp_ctrl); else n_pass++;
         n_total++; if (ex_pc !== m.pc) $display("FAIL rnd_pc[%0d]: got %0h expected %0h", i, ex_pc, m.pc); else n_pass++;
         n_total++; if (alu_a !== ref_operand(m.rs1, m.d1))
            $display("FAIL rnd_alu_a[%0d]: got %0h expected %0h", i, alu_a, ref_operand(m.rs1, m.d1)); else n_pass++;
         n_total++; if (alu_b !== exp_b) $display("FAIL rnd_alu_b[%0d]: got %0h expected %0h", i, alu_b, exp_b); else n_pass++;
         n_total++; if (ex_store_data !== ref_operand(m.rs2, m.d2))
            $display("FAIL rnd_store[%0d]: got %0h expected %0h", i, ex_store_data, ref_operand(m.rs2, m.d2)); else n_pass++;
         tick();
      end
   endtask

   initial begin
      rst = 1;
      set_idle();
      model_reset();
      test_reset();
      test_async_reset();
      test_fwd_exm();
      test_double_match();
      test_load_use();
      test_flush_stall();
      test_raw_stall();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
